// File: rtl/csoc_cmd_sequencer.sv
// Byte-command sequencer driving CSoC reset, scan/test mode, clock bursts and data bus.
// Each accepted opcode produces exactly one reply byte on the UART transmit handshake.
module csoc_cmd_sequencer #(
    parameter int CLK_DIV     = 4,
    parameter int RST_CYCLES  = 8,
    parameter int ARG_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic       csoc_clk,
    output logic       csoc_rstn,
    output logic       csoc_test_se,
    output logic       csoc_test_tm,
    output logic [7:0] csoc_data_o,
    input  logic [7:0] csoc_data_i,
    output logic       busy
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int TO_W  = $clog2(ARG_TIMEOUT + 1);

    localparam logic [7:0] REPLY_OK      = 8'h4B;
    localparam logic [7:0] REPLY_ERR     = 8'h45;
    localparam logic [7:0] REPLY_TIMEOUT = 8'h54;

    typedef enum logic [2:0] {
        S_IDLE, S_ARG, S_PULSE_HI, S_PULSE_LO, S_REPLY, S_WAIT_TX
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [8:0]        pulse_q, pulse_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [1:0]        wt_q, wt_d;
    logic              armed_q, armed_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              clk_q, clk_d;
    logic              rstn_q, rstn_d;
    logic              se_q, se_d;
    logic              tm_q, tm_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            pulse_q   <= '0;
            div_q     <= '0;
            to_q      <= '0;
            wt_q      <= '0;
            armed_q   <= 1'b0;
            tx_data_q <= '0;
            clk_q     <= 1'b0;
            rstn_q    <= 1'b0;
            se_q      <= 1'b0;
            tm_q      <= 1'b0;
            dout_q    <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pulse_q   <= pulse_d;
            div_q     <= div_d;
            to_q      <= to_d;
            wt_q      <= wt_d;
            armed_q   <= armed_d;
            tx_data_q <= tx_data_d;
            clk_q     <= clk_d;
            rstn_q    <= rstn_d;
            se_q      <= se_d;
            tm_q      <= tm_d;
            dout_q    <= dout_d;
            sync1_q   <= csoc_data_i;
            sync2_q   <= sync1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pulse_d   = pulse_q;
        div_d     = div_q;
        to_d      = to_q;
        wt_d      = wt_q;
        armed_d   = armed_q;
        tx_data_d = tx_data_q;
        rstn_d    = rstn_q;
        se_d      = se_q;
        tm_d      = tm_q;
        dout_d    = dout_q;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                to_d  = '0;
                if (new_rx_data) begin
                    op_d = rx_data;
                    case (rx_data)
                        8'h02, 8'h03, 8'h04: state_d = S_ARG;
                        8'h01: begin
                            rstn_d  = 1'b0;
                            pulse_d = 9'(RST_CYCLES);
                            state_d = S_PULSE_HI;
                        end
                        8'h05: begin
                            tx_data_d = sync2_q;
                            state_d   = S_REPLY;
                        end
                        default: begin
                            tx_data_d = REPLY_ERR;
                            state_d   = S_REPLY;
                        end
                    endcase
                end
            end
            S_ARG: begin
                if (new_rx_data) begin
                    tx_data_d = REPLY_OK;
                    case (op_q)
                        8'h02: begin
                            se_d    = rx_data[0];
                            tm_d    = rx_data[1];
                            state_d = S_REPLY;
                        end
                        8'h04: begin
                            dout_d  = rx_data;
                            state_d = S_REPLY;
                        end
                        default: begin
                            // A zero count encodes a full 256-pulse burst.
                            pulse_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                            state_d = S_PULSE_HI;
                        end
                    endcase
                end else if (to_q == TO_W'(ARG_TIMEOUT - 1)) begin
                    tx_data_d = REPLY_TIMEOUT;
                    state_d   = S_REPLY;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_PULSE_HI: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d   = '0;
                    state_d = S_PULSE_LO;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_PULSE_LO: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d   = '0;
                    pulse_d = pulse_q - 9'd1;
                    if (pulse_q == 9'd1) begin
                        tx_data_d = REPLY_OK;
                        state_d   = S_REPLY;
                        if (op_q == 8'h01) rstn_d = 1'b1;
                    end else begin
                        state_d = S_PULSE_HI;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_REPLY: begin
                if (!tx_busy) begin
                    wt_d    = '0;
                    armed_d = 1'b0;
                    state_d = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                // Give the transmitter two cycles to raise busy before trusting its low level.
                if (!armed_q) begin
                    if (tx_busy || wt_q == 2'd1) armed_d = 1'b1;
                    else wt_d = wt_q + 2'd1;
                end else if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        clk_d = (state_d == S_PULSE_HI);
    end

    assign tx_data      = tx_data_q;
    assign new_tx_data  = (state_q == S_REPLY) && !tx_busy;
    assign csoc_clk     = clk_q;
    assign csoc_rstn    = rstn_q;
    assign csoc_test_se = se_q;
    assign csoc_test_tm = tm_q;
    assign csoc_data_o  = dout_q;
    assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_csoc_cmd_sequencer.sv
// Directed bench for csoc_cmd_sequencer: replies checked against a scoreboard queue,
// csoc_clk pulses counted and their high/low widths measured every cycle.
module tb_csoc_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic       csoc_clk;
    logic       csoc_rstn;
    logic       csoc_test_se;
    logic       csoc_test_tm;
    logic [7:0] csoc_data_o;
    logic [7:0] csoc_data_i;
    logic       busy;

    csoc_cmd_sequencer #(.CLK_DIV(4), .RST_CYCLES(8), .ARG_TIMEOUT(100)) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn), .csoc_test_se(csoc_test_se),
        .csoc_test_tm(csoc_test_tm), .csoc_data_o(csoc_data_o),
        .csoc_data_i(csoc_data_i), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int cyc = 0;
    int rises = 0;
    int rst_rises = 0;
    int hi_run = 0;
    int lo_run = 1000;
    logic prev_clk = 1'b0;
    bit chk_w = 1'b1;
    int nrep = 0;
    int last_rep_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples the DUT at the falling edge, then advances past the next rising edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (csoc_clk === 1'b1) begin
            if (!prev_clk) begin
                rises++;
                if (csoc_rstn === 1'b0) rst_rises++;
                if (chk_w && lo_run < 8) chk("lo_width", lo_run, 4);
                hi_run = 0;
            end
            hi_run++;
        end else begin
            if (prev_clk) begin
                if (chk_w) chk("hi_width", hi_run, 4);
                lo_run = 0;
            end
            lo_run++;
        end
        prev_clk = (csoc_clk === 1'b1);
        if (new_tx_data === 1'b1) begin
            nrep++;
            last_rep_cyc = cyc;
            chk("tx_busy_at_strobe", {31'd0, tx_busy}, 0);
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_reply observed=%0h expected=none", tx_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("reply_byte", {24'd0, tx_data}, {24'd0, e});
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        new_rx_data = 1'b1;
        tick();
        new_rx_data = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 0);
        chk({tag, "_new_tx"}, {31'd0, new_tx_data}, 0);
        chk({tag, "_csoc_clk"}, {31'd0, csoc_clk}, 0);
        chk({tag, "_csoc_rstn"}, {31'd0, csoc_rstn}, 0);
        chk({tag, "_se_tm"}, {30'd0, csoc_test_se, csoc_test_tm}, 0);
        chk({tag, "_data_o"}, {24'd0, csoc_data_o}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    initial begin
        int n0;
        rstn = 1'b0;
        rx_data = 8'h00;
        new_rx_data = 1'b0;
        tx_busy = 1'b0;
        csoc_data_i = 8'h00;
        repeat (3) tick();
        chk_reset_vals("reset");
        rstn = 1'b1;
        tick();

        // RESET: 8 pulses with csoc_rstn low, then released
        exp_q.push_back(8'h4B);
        rises = 0; rst_rises = 0;
        send(8'h01);
        chk("busy_during_cmd", {31'd0, busy}, 1);
        wait_idle(400);
        chk("reset_pulses", rises, 8);
        chk("reset_pulses_rstn_low", rst_rises, 8);
        chk("csoc_rstn_released", {31'd0, csoc_rstn}, 1);
        $display("txn RESET pulses=%0d replies=%0d", rises, nrep);

        // CLOCK 5
        exp_q.push_back(8'h4B);
        rises = 0;
        send(8'h03); send(8'h05);
        wait_idle(400);
        chk("clock5_pulses", rises, 5);
        $display("txn CLOCK5 pulses=%0d", rises);

        // CLOCK 0 (=256) with stray bytes mid-burst that must be dropped
        exp_q.push_back(8'h4B);
        rises = 0;
        send(8'h03); send(8'h00);
        repeat (20) tick();
        send(8'h05);
        repeat (5) tick();
        send(8'h7F);
        wait_idle(3000);
        chk("clock256_pulses", rises, 256);
        $display("txn CLOCK256 pulses=%0d", rises);

        // MODE
        exp_q.push_back(8'h4B);
        send(8'h02); send(8'h03);
        wait_idle(50);
        chk("mode_se_tm_11", {30'd0, csoc_test_se, csoc_test_tm}, 3);
        exp_q.push_back(8'h4B);
        send(8'h02); send(8'hFE);
        wait_idle(50);
        chk("mode_se_tm_01", {30'd0, csoc_test_se, csoc_test_tm}, 1);
        $display("txn MODE se=%0b tm=%0b", csoc_test_se, csoc_test_tm);

        // WRITE
        exp_q.push_back(8'h4B);
        send(8'h04); send(8'hA5);
        wait_idle(50);
        chk("write_data", {24'd0, csoc_data_o}, 32'hA5);
        $display("txn WRITE data_o=%0h", csoc_data_o);

        // READ through the synchronizer
        csoc_data_i = 8'h3C;
        repeat (3) tick();
        exp_q.push_back(8'h3C);
        send(8'h05);
        wait_idle(50);
        $display("txn READ replies=%0d", nrep);

        // Unknown opcode
        exp_q.push_back(8'h45);
        send(8'h7F);
        wait_idle(50);
        $display("txn BADOP replies=%0d", nrep);

        // Argument timeout
        exp_q.push_back(8'h54);
        send(8'h04);
        n0 = cyc;
        wait_idle(300);
        chk("timeout_latency_ok", {31'd0, (last_rep_cyc - n0 >= 100) && (last_rep_cyc - n0 <= 101)}, 1);
        chk("timeout_data_unchanged", {24'd0, csoc_data_o}, 32'hA5);
        $display("txn TIMEOUT latency=%0d", last_rep_cyc - n0);

        // Transmitter held busy while the reply is pending
        tx_busy = 1'b1;
        exp_q.push_back(8'h4B);
        n0 = nrep;
        send(8'h04); send(8'h11);
        repeat (50) tick();
        chk("held_no_reply", nrep, n0);
        chk("held_busy", {31'd0, busy}, 1);
        tx_busy = 1'b0;
        wait_idle(50);
        chk("held_one_reply", nrep, n0 + 1);
        chk("held_write_data", {24'd0, csoc_data_o}, 32'h11);
        $display("txn TXBUSY replies=%0d", nrep - n0);

        // Reset in the middle of a burst aborts without a reply
        n0 = nrep;
        send(8'h03); send(8'h00);
        repeat (30) tick();
        chk_w = 1'b0;
        rstn = 1'b0;
        tick();
        chk_reset_vals("midreset");
        rstn = 1'b1;
        repeat (30) tick();
        chk("midreset_no_reply", nrep, n0);
        chk("midreset_idle", {31'd0, busy}, 0);
        $display("txn MIDRESET replies=%0d", nrep - n0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csoc_cmd_sequencer.md
Name: csoc_cmd_sequencer

Overview:
Command sequencer between the UART byte interface and the CSoC test pins. It decodes single-byte opcodes with optional one-byte arguments, then executes them:
- drives CSoC reset, scan-enable and test-mode;
- generates a counted burst of CSoC clock pulses;
- writes or reads the CSoC data bus.

Every command returns exactly one reply byte through the UART transmitter handshake.

Parameters:
CLK_DIV, 4, system clocks per csoc_clk half-period (>=1)
RST_CYCLES, 8, csoc_clk periods that csoc_rstn is held low by the RESET command (>=1)
ARG_TIMEOUT, 1000000, system clocks to wait for an argument byte before aborting

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
rx_data  in  8  received UART byte
new_rx_data  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  reply byte to transmit
new_tx_data  out  1  one-cycle strobe requesting transmission of tx_data
tx_busy  in  1  transmitter busy
csoc_clk  out  1  CSoC clock, generated only during CLOCK/RESET commands
csoc_rstn  out  1  CSoC reset, active low
csoc_test_se  out  1  CSoC scan enable
csoc_test_tm  out  1  CSoC test mode
csoc_data_o  out  8  data driven to CSoC
csoc_data_i  in  8  data from CSoC (asynchronous)
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: reset rstn, synchronous, active-low; clock clk.
  - Reset values: tx_data=0x00, new_tx_data=0, csoc_clk=0, csoc_rstn=0, csoc_test_se=0, csoc_test_tm=0, csoc_data_o=0x00, busy=0; FSM in IDLE; all counters 0.
  - csoc_rstn stays 0 until the first RESET command completes.
  - rstn asserted mid-command aborts it immediately; no reply is sent.
- csoc_data_i passes through a 2-flop synchronizer; READ returns the synchronizer output.
- Opcodes, with reply byte:
  - 0x01 RESET: csoc_rstn=0, run RST_CYCLES csoc_clk pulses, then csoc_rstn=1. Reply 'K' (0x4B).
  - 0x02 MODE + arg: csoc_test_se=arg[0], csoc_test_tm=arg[1]; arg[7:2] ignored. Reply 'K'.
  - 0x03 CLOCK + arg: emit N pulses, N=arg, arg=0 means 256. Reply 'K'.
  - 0x04 WRITE + arg: csoc_data_o=arg. Reply 'K'.
  - 0x05 READ: reply is the synchronized csoc_data_i, sampled in the cycle the FSM enters REPLY.
  - Any other opcode: reply 'E' (0x45).
- FSM states: IDLE, ARG, PULSE_HI, PULSE_LO, REPLY, WAIT_TX.
  - IDLE: on new_rx_data, latch the opcode. 0x02/0x03/0x04 go to ARG; 0x01 sets csoc_rstn=0, loads pulse counter=RST_CYCLES, goes to PULSE_HI; all others go to REPLY.
  - ARG: on new_rx_data, latch arg and apply MODE/WRITE in that cycle, then go to REPLY. For CLOCK, load pulse counter and go to PULSE_HI. If ARG_TIMEOUT clocks elapse with no byte, reply 'T' (0x54) and do not apply the command.
  - PULSE_HI: csoc_clk=1 for CLK_DIV clocks, then go to PULSE_LO.
  - PULSE_LO: csoc_clk=0 for CLK_DIV clocks, decrement the counter. If counter≠0, go to PULSE_HI. If 0, go to REPLY; for RESET, set csoc_rstn=1 on this transition.
  - REPLY: wait while tx_busy=1. When tx_busy=0, load tx_data, pulse new_tx_data for exactly one cycle, go to WAIT_TX.
  - WAIT_TX: wait until tx_busy=1 is seen, or 2 cycles elapse. Then wait for tx_busy=0, then go to IDLE.
- Pulse timing:
  - Each pulse period is exactly 2*CLK_DIV clocks.
  - The first rising edge of csoc_clk occurs 1 clock after entering PULSE_HI.
  - csoc_clk is 0 in every state except PULSE_HI.
- new_rx_data while busy and not in ARG: byte dropped silently; no reply, no state change.
- new_rx_data in the same cycle the FSM returns to IDLE: dropped (busy still 1 that cycle).
- Counters: pulse counter 9 bits; divider counter ceil(log2(CLK_DIV+1)) bits; timeout counter wide enough for ARG_TIMEOUT. No wrap is permitted within a command.
- new_tx_data is never asserted while tx_busy=1. Exactly one reply per accepted opcode.

Test Plan:
- Reset, then 0x01 with RST_CYCLES=8, CLK_DIV=4 -> csoc_rstn low during exactly 8 csoc_clk pulses, each 4 high/4 low clocks; csoc_rstn=1 after the last falling edge; reply 0x4B; busy returns to 0.
- 0x03, 0x05 -> exactly 5 rising edges on csoc_clk, reply 'K'. Then 0x03, 0x00 -> exactly 256 rising edges.
- 0x02, 0x03 -> se=1, tm=1. 0x04, 0xA5 -> csoc_data_o=0xA5. Then csoc_data_i=0x3C, send 0x05 -> reply byte 0x3C.
- Opcode 0x7F -> reply 0x45. 0x04 with no argument and ARG_TIMEOUT=100 -> reply 0x54 after 100 clocks; csoc_data_o unchanged.
- tx_busy held 1 for 50 clocks when a reply is ready -> new_tx_data stays 0 until tx_busy falls, then one single-cycle pulse; extra rx bytes sent during a CLOCK burst are ignored.
- rstn asserted mid-CLOCK burst -> all outputs return to reset values next cycle; no reply emitted.
